// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared stall-bus indices, FSM encodings and defaults for the pipeline controller
package pipeline_ctrl_pkg;
  localparam int STALL_W = 6;
  localparam int STALL_PC = 0;
  localparam int STALL_IF = 1;
  localparam int STALL_ID = 2;
  localparam int STALL_EX = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB = 5;
  localparam int PCTRL_FLUSH_LEN = 1;
  localparam logic [STALL_W-1:0] STALL_FREEZE = '1;
  typedef enum logic [1:0] {
    PCTRL_RUN = 2'd0,
    PCTRL_PEND = 2'd1,
    PCTRL_FLUSH = 2'd2
  } pctrl_state_e;
  function automatic logic [STALL_W-1:0] stall_upto(input int k);
    return STALL_W'((1 << (k + 1)) - 1);
  endfunction
endpackage

// File: rtl/pipeline_ctrl_stall_encoder.sv
// pipeline_ctrl_stall_encoder: stalls every stage up to the deepest requesting one
module pipeline_ctrl_stall_encoder
  import pipeline_ctrl_pkg::*;
(
  input  logic               req_if,
  input  logic               req_id,
  input  logic               req_ex,
  input  logic               req_mem,
  output logic [STALL_W-1:0] stall
);
  always_comb
    stall = req_mem ? stall_upto(STALL_MEM) :
            req_ex  ? stall_upto(STALL_EX)  :
            req_id  ? stall_upto(STALL_ID)  :
            req_if  ? stall_upto(STALL_IF)  : '0;
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: per-stage stall vector, exception/ERET flush arbitration and stall-cycle counter
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int FLUSH_LEN = PCTRL_FLUSH_LEN,
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_req_if,
  input  logic               stall_req_id,
  input  logic               stall_req_ex,
  input  logic               stall_req_mem,
  input  logic               exc_req,
  input  logic [ADDR_W-1:0]  exc_handler_pc,
  input  logic               eret_req,
  input  logic [ADDR_W-1:0]  epc,
  input  logic               cnt_clr,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic [ADDR_W-1:0]  flush_pc,
  output logic               exc_pending,
  output logic [CNT_W-1:0]   stall_cycles
);
  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_LEN - 1);
  pctrl_state_e state_q, state_d;
  logic [ADDR_W-1:0] flush_pc_q, flush_pc_d;
  logic [3:0] fcnt_q, fcnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [STALL_W-1:0] enc_stall;
  pipeline_ctrl_stall_encoder u_enc (
    .req_if (stall_req_if),
    .req_id (stall_req_id),
    .req_ex (stall_req_ex),
    .req_mem(stall_req_mem),
    .stall  (enc_stall)
  );
  always_comb begin
    state_d = state_q;
    flush_pc_d = flush_pc_q;
    fcnt_d = fcnt_q;
    stall = enc_stall;
    case (state_q)
      PCTRL_RUN:
        if (exc_req || eret_req) begin
          flush_pc_d = exc_req ? exc_handler_pc : epc;
          state_d = stall_req_mem ? PCTRL_PEND : PCTRL_FLUSH;
          fcnt_d = '0;
          stall = stall_req_mem ? enc_stall : STALL_FREEZE;
        end
      PCTRL_PEND:
        if (!stall_req_mem) begin
          stall = STALL_FREEZE;
          state_d = PCTRL_FLUSH;
          fcnt_d = '0;
        end
      PCTRL_FLUSH: begin
        stall = '0;
        fcnt_d = fcnt_q + 4'd1;
        state_d = (fcnt_q == FLUSH_LAST) ? PCTRL_RUN : PCTRL_FLUSH;
      end
      default: state_d = PCTRL_RUN;
    endcase
    stall_cycles_d = cnt_clr ? '0 :
                     (stall[STALL_PC] && !(&stall_cycles_q)) ? stall_cycles_q + CNT_W'(1) :
                     stall_cycles_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= PCTRL_RUN;
      flush_pc_q <= '0;
      fcnt_q <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q <= state_d;
      flush_pc_q <= flush_pc_d;
      fcnt_q <= fcnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  assign flush = state_q == PCTRL_FLUSH;
  assign exc_pending = state_q == PCTRL_PEND;
  assign flush_pc = flush_pc_q;
  assign stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed and random stimulus on two configurations against a behavioural model
module tb_pipeline_ctrl;
  logic clk = 0, rst = 0;
  logic r_if = 0, r_id = 0, r_ex = 0, r_mem = 0, exc = 0, eret = 0, clr = 0;
  logic [31:0] hpc = 0, epc = 0;
  logic [5:0] st0, st1;
  logic fl0, fl1, pe0, pe1;
  logic [31:0] fpc0, fpc1;
  logic [3:0] cyc0;
  logic [31:0] cyc1;
  int errors = 0, checks = 0;
  int flen[2] = '{3, 1};
  longint cmax[2] = '{15, 64'hFFFF_FFFF};
  int fl_left[2];
  bit pend[2];
  logic [31:0] tgt[2];
  longint cyc[2];
  always #5 clk = ~clk;
  pipeline_ctrl #(.ADDR_W(32), .FLUSH_LEN(3), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .stall_req_if(r_if), .stall_req_id(r_id), .stall_req_ex(r_ex),
    .stall_req_mem(r_mem), .exc_req(exc), .exc_handler_pc(hpc), .eret_req(eret), .epc(epc),
    .cnt_clr(clr), .stall(st0), .flush(fl0), .flush_pc(fpc0), .exc_pending(pe0), .stall_cycles(cyc0)
  );
  pipeline_ctrl dut1 (
    .clk(clk), .rst(rst), .stall_req_if(r_if), .stall_req_id(r_id), .stall_req_ex(r_ex),
    .stall_req_mem(r_mem), .exc_req(exc), .exc_handler_pc(hpc), .eret_req(eret), .epc(epc),
    .cnt_clr(clr), .stall(st1), .flush(fl1), .flush_pc(fpc1), .exc_pending(pe1), .stall_cycles(cyc1)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [5:0] req_stall();
    int k;
    k = r_mem ? 4 : r_ex ? 3 : r_id ? 2 : r_if ? 1 : 0;
    return k == 0 ? 6'd0 : 6'((1 << (k + 1)) - 1);
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      fl_left[i] = 0;
      pend[i] = 0;
      tgt[i] = 0;
      cyc[i] = 0;
    end
  endtask
  task automatic drive(input bit f, d, x, m, e, r, input logic [31:0] hp, ep, input bit c);
    {r_if, r_id, r_ex, r_mem, exc, eret, clr} = {f, d, x, m, e, r, c};
    hpc = hp;
    epc = ep;
    #1;
  endtask
  task automatic step();
    logic [5:0] es[2];
    #1;
    for (int i = 0; i < 2; i++) begin
      bit fl;
      fl = fl_left[i] > 0;
      es[i] = fl ? 6'd0 : pend[i] ? (r_mem ? req_stall() : 6'h3F)
                        : ((exc || eret) && !r_mem) ? 6'h3F : req_stall();
      chk($sformatf("stall%0d", i), i ? st1 : st0, es[i]);
      chk($sformatf("flush%0d", i), i ? fl1 : fl0, fl);
      chk($sformatf("pending%0d", i), i ? pe1 : pe0, !fl && pend[i]);
      chk($sformatf("cycles%0d", i), i ? 64'(cyc1) : 64'(cyc0), cyc[i]);
      if (fl) chk($sformatf("flush_pc%0d", i), i ? fpc1 : fpc0, tgt[i]);
    end
    for (int i = 0; i < 2; i++) begin
      if (fl_left[i] > 0) fl_left[i]--;
      else if (pend[i]) begin
        if (!r_mem) begin
          pend[i] = 0;
          fl_left[i] = flen[i];
        end
      end else if (exc || eret) begin
        tgt[i] = exc ? hpc : epc;
        if (r_mem) pend[i] = 1;
        else fl_left[i] = flen[i];
      end
      cyc[i] = clr ? 0 : es[i][0] ? (cyc[i] < cmax[i] ? cyc[i] + 1 : cyc[i]) : cyc[i];
    end
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    for (int j = 0; j < n; j++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
    end
  endtask
  task automatic check_reset();
    chk("rst_flush0", fl0, 0);
    chk("rst_flush1", fl1, 0);
    chk("rst_pend0", pe0, 0);
    chk("rst_fpc1", fpc1, 0);
    chk("rst_cyc0", cyc0, 0);
    chk("rst_cyc1", cyc1, 0);
    chk("rst_stall1", st1, 0);
  endtask
  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check_reset();
    @(negedge clk);
    rst = 1;
    idle(2);
    drive(0, 1, 1, 0, 0, 0, 0, 0, 0);
    chk("lit_idex", st1, 6'b001111);
    step();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("lit_if", st1, 6'b000011);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step();
    for (int j = 0; j < 5; j++) begin
      drive(0, 0, 0, 1, 0, 0, 0, 0, 0);
      chk("lit_mem", st1, 6'b011111);
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("lit_cyc5", cyc1, 5);
    step();
    drive(0, 0, 0, 0, 1, 0, 32'hBFC00380, 0, 0);
    chk("lit_freeze", st1, 6'h3F);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("lit_exc_pc", fpc1, 32'hBFC00380);
    step();
    idle(3);
    drive(0, 0, 0, 1, 1, 0, 32'hBFC00380, 0, 0);
    step();
    drive(0, 0, 0, 1, 1, 0, 32'h0, 0, 0);
    step();
    drive(0, 0, 0, 1, 0, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("lit_pend_freeze", st1, 6'h3F);
    step();
    chk("lit_def_pc", fpc1, 32'hBFC00380);
    idle(4);
    drive(0, 0, 0, 0, 1, 1, 32'hBFC00380, 32'h80001000, 0);
    step();
    idle(4);
    drive(0, 0, 0, 0, 0, 1, 0, 32'h80001000, 0);
    step();
    for (int j = 0; j < 4; j++) begin
      drive(1, 1, 1, 1, 1, 0, 32'h1234, 0, 0);
      step();
    end
    idle(2);
    drive(0, 0, 0, 0, 1, 0, 32'hAAAA0000, 0, 0);
    step();
    drive(0, 0, 0, 0, 1, 0, 32'h5555, 0, 0);
    step();
    idle(4);
    for (int j = 0; j < 400; j++) begin
      drive($urandom_range(2) == 0, $urandom_range(3) == 0, $urandom_range(3) == 0,
            $urandom_range(2) == 0, $urandom_range(7) == 0, $urandom_range(7) == 0,
            $urandom, $urandom, $urandom_range(31) == 0);
      step();
    end
    idle(4);
    drive(0, 0, 0, 1, 0, 0, 0, 0, 1);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("lit_clr0", cyc0, 0);
    chk("lit_clr1", cyc1, 0);
    step();
    drive(0, 0, 0, 0, 1, 0, 32'hBFC00380, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("pre_rst_flush0", fl0, 1);
    rst = 0;
    #1;
    check_reset();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
